// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Frame sequencer between the GPIO control block and the convolution datapath.
// It buffers the image columns loaded by the control block and streams them to
// the convolution unit. It collects the results and signals end-of-process.
// After that it serves the results to the MCU, one word per read request.
//
// Ports
//   i_CLK        clock
//   i_rst        synchronous active-high reset (aborts any frame in flight)
//   i_valid      one-cycle load strobe, i_data sampled with it
//   i_data       image column word (3 x 8-bit pixels)
//   i_imgLength  number of columns in the frame
//   i_SoP        start-of-process level; sampled in LOAD only
//   i_res        convolution result
//   i_res_valid  result strobe
//   i_rd_req     one-cycle MCU read-advance pulse
//   o_conv_data  column word to the convolution unit
//   o_conv_valid column strobe
//   o_EoP        one-cycle end-of-process pulse
//   o_MCUdata    result word currently addressed by the MCU read pointer
//   o_ovf        sticky: a load word was dropped because the frame was full
//   o_state      LOAD=0, RUN=1, DRAIN=2, DONE=3
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
   parameter int DATA_W = 24,
   parameter int RES_W  = 13,
   parameter int ADDR_W = 11,
   parameter int KSIZE  = 3
) (
   input  logic              i_CLK,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] i_imgLength,
   input  logic              i_SoP,
   input  logic [RES_W-1:0]  i_res,
   input  logic              i_res_valid,
   input  logic              i_rd_req,
   output logic [DATA_W-1:0] o_conv_data,
   output logic              o_conv_valid,
   output logic              o_EoP,
   output logic [RES_W-1:0]  o_MCUdata,
   output logic              o_ovf,
   output logic [1:0]        o_state
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_res_cnt;
   logic [ADDR_W-1:0] r_mcu_ptr;
   logic [ADDR_W-1:0] r_len_q;
   logic [ADDR_W-1:0] r_exp_q;
   logic              r_issue;     // a read of in_mem was issued last edge
   logic [DATA_W-1:0] r_in_q;      // synchronous read data of in_mem

   logic [DATA_W-1:0] r_in_mem  [0:DEPTH-1];
   logic [RES_W-1:0]  r_res_mem [0:DEPTH-1];

   logic              w_load_wr;
   logic [ADDR_W-1:0] w_load_addr;
   logic              w_res_acc;
   logic [ADDR_W-1:0] w_res_cnt_nxt;
   logic              w_issue;
   logic [ADDR_W-1:0] w_exp;

   // A load strobe in DONE restarts the frame and always lands at address 0.
   always_comb begin
      w_load_wr   = 1'b0;
      w_load_addr = r_wr_ptr;
      if (!i_rst && i_valid) begin
         if (r_state == S_LOAD && r_wr_ptr < i_imgLength) begin
            w_load_wr = 1'b1;
         end else if (r_state == S_DONE) begin
            w_load_wr   = 1'b1;
            w_load_addr = '0;
         end
      end
   end

   // Surplus results beyond the expected count are dropped here.
   assign w_res_acc     = !i_rst && i_res_valid && r_res_cnt < r_exp_q &&
                          (r_state == S_RUN || r_state == S_DRAIN);
   assign w_res_cnt_nxt = r_res_cnt + {{(ADDR_W-1){1'b0}}, w_res_acc};
   assign w_issue       = r_state == S_RUN && r_len_q != '0;
   assign w_exp         = (i_imgLength >= ADDR_W'(KSIZE)) ?
                          i_imgLength - ADDR_W'(KSIZE-1) : '0;

   // Memories: no reset, contents survive a frame abort.
   always_ff @(posedge i_CLK) begin
      if (w_load_wr) r_in_mem[w_load_addr] <= i_data;
      if (w_res_acc) r_res_mem[r_res_cnt]  <= i_res;
      r_in_q <= r_in_mem[r_rd_ptr];
   end

   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         r_state      <= S_LOAD;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_res_cnt    <= '0;
         r_mcu_ptr    <= '0;
         r_len_q      <= '0;
         r_exp_q      <= '0;
         r_issue      <= 1'b0;
         o_conv_data  <= '0;
         o_conv_valid <= 1'b0;
         o_EoP        <= 1'b0;
         o_MCUdata    <= '0;
         o_ovf        <= 1'b0;
      end else begin
         o_EoP        <= 1'b0;
         // Issue edge registers the read, the next edge presents it.
         r_issue      <= w_issue;
         o_conv_valid <= r_issue;
         if (r_issue) o_conv_data <= r_in_q;
         if (w_res_acc) r_res_cnt <= w_res_cnt_nxt;

         case (r_state)
            S_LOAD: begin
               if (i_valid) begin
                  if (r_wr_ptr < i_imgLength) r_wr_ptr <= r_wr_ptr + 1'b1;
                  else                        o_ovf    <= 1'b1;
               end
               if (i_SoP) begin
                  r_len_q   <= i_imgLength;
                  r_exp_q   <= w_exp;
                  r_rd_ptr  <= '0;
                  r_res_cnt <= '0;
                  r_state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_len_q == '0) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (r_rd_ptr == r_len_q - 1'b1) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Count includes a result accepted on this same edge.
               if (w_res_cnt_nxt == r_exp_q) begin
                  r_state   <= S_DONE;
                  o_EoP     <= 1'b1;
                  r_mcu_ptr <= '0;
               end
            end
            S_DONE: begin
               o_MCUdata <= r_res_mem[r_mcu_ptr];
               if (i_rd_req) begin
                  if (r_exp_q == '0 || r_mcu_ptr == r_exp_q - 1'b1)
                     r_mcu_ptr <= '0;
                  else
                     r_mcu_ptr <= r_mcu_ptr + 1'b1;
               end
               if (i_valid) begin
                  r_state  <= S_LOAD;
                  r_wr_ptr <= ADDR_W'(1);
                  o_ovf    <= 1'b0;
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;
   localparam int DATA_W = 24;
   localparam int RES_W  = 13;
   localparam int ADDR_W = 11;
   localparam int KSIZE  = 3;
   localparam int MAXC   = 400;

   logic              i_CLK = 1'b0;
   logic              i_rst, i_valid, i_SoP, i_res_valid, i_rd_req;
   logic [DATA_W-1:0] i_data;
   logic [ADDR_W-1:0] i_imgLength;
   logic [RES_W-1:0]  i_res;
   logic [DATA_W-1:0] o_conv_data;
   logic              o_conv_valid, o_EoP, o_ovf;
   logic [RES_W-1:0]  o_MCUdata;
   logic [1:0]        o_state;

   always #5 i_CLK = ~i_CLK;

   conv_frame_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W), .ADDR_W(ADDR_W), .KSIZE(KSIZE)) dut (
      .i_CLK(i_CLK), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
      .i_imgLength(i_imgLength), .i_SoP(i_SoP), .i_res(i_res),
      .i_res_valid(i_res_valid), .i_rd_req(i_rd_req),
      .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid), .o_EoP(o_EoP),
      .o_MCUdata(o_MCUdata), .o_ovf(o_ovf), .o_state(o_state));

   int checks = 0;
   int errors = 0;

   // Reference model: image buffer contents, load pointer, flags.
   logic [DATA_W-1:0] mem_model [0:2047];
   int                m_wptr;
   bit                m_ovf, m_done;
   logic [RES_W-1:0]  stored[$];

   // Per-cycle observations and expectations of one frame run.
   logic [1:0]        obs_st[MAXC], exp_st[MAXC];
   logic              obs_eop[MAXC], exp_eo[MAXC], obs_cv[MAXC], exp_cv[MAXC];
   logic [DATA_W-1:0] obs_cd[MAXC], exp_cd[MAXC];
   int                ncyc, run_eop;

   task automatic load_word(input logic [DATA_W-1:0] w, input int len);
      @(negedge i_CLK);
      i_valid = 1'b1; i_data = w; i_imgLength = ADDR_W'(len);
      if (m_done) begin
         mem_model[0] = w; m_wptr = 1; m_ovf = 1'b0; m_done = 1'b0;
      end else if (m_wptr < len) begin
         mem_model[m_wptr] = w; m_wptr++;
      end else begin
         m_ovf = 1'b1;
      end
      @(negedge i_CLK);
      i_valid = 1'b0;
   endtask

   // Raises SoP and runs the frame to one cycle past EoP, recording the DUT and
   // building expectations from the frame rules: RUN lasts max(len,1) cycles,
   // strobe k appears 3+k cycles after the SoP drive cycle, results sent while
   // RUN/DRAIN are kept up to len-(KSIZE-1), EoP follows the first DRAIN cycle
   // in which that count is reached.
   // rnd=0: conv-unit model, result j returned lat cycles after strobe j+KSIZE-1.
   // rnd=1: results injected at random cycles. extra = surplus results sent.
   task automatic do_run(input int len, input bit rnd, input int lat, input int extra);
      int L, ex, cap, sent, mst, j;
      bit send;
      logic [RES_W-1:0] v;
      L = (len == 0) ? 1 : len;
      ex = (len >= KSIZE) ? len - (KSIZE-1) : 0;
      stored.delete(); cap = 0; sent = 0; run_eop = -1; ncyc = 0;
      @(negedge i_CLK);
      i_SoP = 1'b1; i_imgLength = ADDR_W'(len);
      for (int c = 1; c < MAXC; c++) begin
         @(negedge i_CLK);
         i_SoP = 1'b0;
         obs_st[c] = o_state; obs_eop[c] = o_EoP; obs_cv[c] = o_conv_valid; obs_cd[c] = o_conv_data;
         mst = (run_eop >= 0 && c >= run_eop) ? 3 : (c <= L) ? 1 : 2;
         exp_st[c] = 2'(mst);
         exp_eo[c] = (c == run_eop);
         exp_cv[c] = (c >= 3 && c < 3 + len);
         exp_cd[c] = exp_cv[c] ? mem_model[c-3] : '0;
         if (rnd) begin
            send = (mst != 3) && (sent < ex + extra) && ($urandom_range(0, 1) == 1);
            v = RES_W'($urandom);
         end else begin
            j = c - 3 - (KSIZE-1) - lat;
            send = (j >= 0) && (j < ex + extra);
            v = RES_W'(100 + j);
         end
         if (send) sent++;
         i_res_valid = send; i_res = v;
         if (send && mst != 3 && cap < ex) begin stored.push_back(v); cap++; end
         if (mst == 2 && cap == ex && run_eop < 0) run_eop = c + 1;
         ncyc = c;
         if (run_eop >= 0 && c >= run_eop + 1) break;
      end
      i_res_valid = 1'b0;
      checks++;
      if (!(run_eop >= 0 && ncyc >= run_eop + 1)) begin
         errors++; $display("FAIL run_bound len %0d cycles %0d eop %0d", len, ncyc, run_eop);
      end
      m_done = 1'b1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 0; i_SoP = 0; i_res_valid = 0; i_rd_req = 0;
      i_data = '0; i_imgLength = '0; i_res = '0;
      repeat (3) @(negedge i_CLK);
      checks++;
      if ({o_state, o_conv_valid, o_EoP, o_ovf} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl got st=%0d cv=%0d eop=%0d ovf=%0d exp 0", o_state, o_conv_valid, o_EoP, o_ovf);
      end
      checks++;
      if ({o_MCUdata, o_conv_data} !== '0) begin
         errors++; $display("FAIL reset_data got mcu=%h cd=%h exp 0", o_MCUdata, o_conv_data);
      end
      i_rst = 1'b0; m_wptr = 0; m_ovf = 1'b0; m_done = 1'b0;
   endtask

   task automatic test_basic();
      int neop, ceop;
      for (int k = 0; k < 8; k++) load_word({8'(k+1), 8'(k+2), 8'(k+3)}, 8);
      checks++;
      if (o_state !== 2'd0) begin errors++; $display("FAIL basic_load_state got %0d exp 0", o_state); end
      do_run(8, 1'b0, 4, 1);
      neop = 0; ceop = -1;
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
             (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
            errors++; $display("FAIL basic_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
               c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
         end
         if (obs_eop[c]) begin neop++; ceop = c; end
      end
      checks++;
      if (neop != 1 || ceop != 15) begin errors++; $display("FAIL basic_eop got count %0d cycle %0d exp 1 at 15", neop, ceop); end
      checks++;
      if (o_MCUdata !== 13'd100) begin errors++; $display("FAIL basic_mcu0 got %0d exp 100", o_MCUdata); end
      for (int r = 1; r <= 6; r++) begin
         @(negedge i_CLK); i_rd_req = 1'b1;
         @(negedge i_CLK); i_rd_req = 1'b0;
         @(negedge i_CLK);
         checks++;
         if (o_MCUdata !== RES_W'(100 + (r % 6))) begin
            errors++; $display("FAIL basic_mcu_rd%0d got %0d exp %0d", r, o_MCUdata, 100 + (r % 6));
         end
      end
   endtask

   task automatic test_short();
      load_word(24'hAA0001, 2);
      load_word(24'hAA0002, 2);
      do_run(2, 1'b0, -3, 2);   // two results arrive in RUN/DRAIN, none expected
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
             (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
            errors++; $display("FAIL short_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
               c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
         end
      end
      checks++;
      if (obs_eop[4] !== 1'b1 || obs_st[3] !== 2'd2) begin
         errors++; $display("FAIL short_eop got eop@4=%0d st@3=%0d exp 1 and 2", obs_eop[4], obs_st[3]);
      end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 6; k++) begin
         load_word(24'h500000 + 24'(k), 4);
         checks++;
         if (o_ovf !== m_ovf) begin errors++; $display("FAIL ovf_load%0d got %0d exp %0d", k, o_ovf, m_ovf); end
      end
      do_run(4, 1'b1, 0, 1);
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
             (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
            errors++; $display("FAIL ovf_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
               c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
         end
      end
      checks++;
      if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d exp 1", o_ovf); end
      load_word(24'h5A5A5A, 4);
      checks++;
      if ({o_ovf, o_state} !== 3'b000) begin
         errors++; $display("FAIL ovf_clear got ovf=%0d st=%0d exp 0/0", o_ovf, o_state);
      end
      for (int k = 1; k < 4; k++) load_word(24'h600000 + 24'(k), 4);
      do_run(4, 1'b1, 0, 0);
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
             (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
            errors++; $display("FAIL ovf2_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
               c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      for (int k = 0; k < 8; k++) load_word(24'($urandom), 8);
      @(negedge i_CLK); i_SoP = 1'b1; i_imgLength = 11'd8;
      @(negedge i_CLK); i_SoP = 1'b0;
      repeat (3) @(negedge i_CLK);   // three reads issued, read pointer at 3
      checks++;
      if ({o_state, o_conv_valid} !== 3'b011) begin
         errors++; $display("FAIL midrst_pre got st=%0d cv=%0d exp 1/1", o_state, o_conv_valid);
      end
      i_rst = 1'b1;
      @(negedge i_CLK);
      checks++;
      if ({o_state, o_conv_valid, o_EoP, o_ovf} !== 5'b0 || o_MCUdata !== '0) begin
         errors++; $display("FAIL midrst_post got st=%0d cv=%0d eop=%0d ovf=%0d mcu=%h exp 0",
            o_state, o_conv_valid, o_EoP, o_ovf, o_MCUdata);
      end
      i_rst = 1'b0; m_wptr = 0; m_ovf = 1'b0; m_done = 1'b0;
      for (int k = 0; k < 8; k++) load_word(24'($urandom), 8);
      do_run(8, 1'b0, 2, 0);
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
             (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
            errors++; $display("FAIL rerun_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
               c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
         end
      end
      checks++;
      if (o_MCUdata !== stored[0]) begin errors++; $display("FAIL rerun_mcu0 got %0d exp %0d", o_MCUdata, stored[0]); end
   endtask

   task automatic test_zero_len();
      int ncv, neop;
      load_word(24'h0F0F0F, 0);
      checks++;
      if (o_state !== 2'd0) begin errors++; $display("FAIL zero_load_state got %0d exp 0", o_state); end
      do_run(0, 1'b0, 0, 0);
      ncv = 0; neop = 0;
      for (int c = 1; c <= ncyc; c++) begin
         checks++;
         if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]}) begin
            errors++; $display("FAIL zero_cyc%0d st/eop/cv got %0d/%0d/%0d exp %0d/%0d/%0d",
               c, obs_st[c], obs_eop[c], obs_cv[c], exp_st[c], exp_eo[c], exp_cv[c]);
         end
         ncv += int'(obs_cv[c]); neop += int'(obs_eop[c]);
      end
      checks++;
      if (ncv != 0 || neop != 1 || o_state !== 2'd3) begin
         errors++; $display("FAIL zero_summary got cv=%0d eop=%0d st=%0d exp 0/1/3", ncv, neop, o_state);
      end
   endtask

   task automatic test_random();
      int len, n;
      for (int it = 0; it < 5; it++) begin
         len = $urandom_range(3, 24);
         for (int k = 0; k < len; k++) load_word(24'($urandom), len);
         do_run(len, 1'b1, 0, $urandom_range(0, 2));
         for (int c = 1; c <= ncyc; c++) begin
            checks++;
            if ({obs_st[c], obs_eop[c], obs_cv[c]} !== {exp_st[c], exp_eo[c], exp_cv[c]} ||
                (exp_cv[c] && obs_cd[c] !== exp_cd[c])) begin
               errors++; $display("FAIL rand%0d_cyc%0d st/eop/cv/data got %0d/%0d/%0d/%h exp %0d/%0d/%0d/%h",
                  it, c, obs_st[c], obs_eop[c], obs_cv[c], obs_cd[c], exp_st[c], exp_eo[c], exp_cv[c], exp_cd[c]);
            end
         end
         n = stored.size();
         checks++;
         if (o_MCUdata !== stored[0]) begin errors++; $display("FAIL rand%0d_mcu0 got %0d exp %0d", it, o_MCUdata, stored[0]); end
         for (int r = 1; r <= n; r++) begin
            @(negedge i_CLK); i_rd_req = 1'b1;
            @(negedge i_CLK); i_rd_req = 1'b0;
            @(negedge i_CLK);
            checks++;
            if (o_MCUdata !== stored[r % n]) begin
               errors++; $display("FAIL rand%0d_mcu_rd%0d got %0d exp %0d", it, r, o_MCUdata, stored[r % n]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_overflow();
      test_reset_midrun();
      test_zero_len();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
